mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/nsc8_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/nsc8_pkg.sv
// rtl/nsc8_pkg.sv - shared arbiter state type and datapath widths
package nsc8_pkg;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        LDR  = 2'd2,
        TURN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU / program-loader RAM port arbiter with turnaround cycle
// Optional burst limiting is enabled with `define MEM_ARB_BURST_LIMIT_EN.
module mem_arbiter
    import nsc8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              cpu_gnt,
    output logic              ldr_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              cpu_stall
);

    arb_state_t state_q, state_d;
    logic       last_ldr_q, last_ldr_d;  // 1 when the loader was the most recent owner
    logic       owner_req;
    logic       other_req;
    logic       burst_done;
    logic       entering;

    always_comb begin
        owner_req = 1'b0;
        other_req = 1'b0;
        case (state_q)
            CPU: begin
                owner_req = cpu_req;
                other_req = ldr_req;
            end
            LDR: begin
                owner_req = ldr_req;
                other_req = cpu_req;
            end
            default: begin
                owner_req = 1'b0;
                other_req = 1'b0;
            end
        endcase
    end

`ifdef MEM_ARB_BURST_LIMIT_EN
    logic [1:0] beat_q, beat_d;

    // The beat in progress is the last one allowed when beat_q has reached BURST_MAX-1.
    assign burst_done = (beat_q == 2'(BURST_MAX - 1)) & owner_req & other_req;

    always_comb begin
        beat_d = beat_q;
        if (entering) begin
            beat_d = 2'd0;
        end else if (owner_req && beat_q != 2'(BURST_MAX - 1)) begin
            beat_d = beat_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= 2'd0;
        end else begin
            beat_q <= beat_d;
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_req && ldr_req) begin
                    state_d = last_ldr_q ? CPU : LDR;
                end else if (cpu_req) begin
                    state_d = CPU;
                end else if (ldr_req) begin
                    state_d = LDR;
                end
            end
            CPU, LDR: begin
                if (!owner_req) begin
                    state_d = other_req ? TURN : IDLE;
                end else if (burst_done) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                // The waiting side is whoever did not own the port last.
                if (last_ldr_q) begin
                    state_d = cpu_req ? CPU : IDLE;
                end else begin
                    state_d = ldr_req ? LDR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign entering = (state_d != state_q) && (state_d == CPU || state_d == LDR);

    always_comb begin
        last_ldr_d = last_ldr_q;
        if (entering) begin
            last_ldr_d = (state_d == LDR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_ldr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_ldr_q <= last_ldr_d;
        end
    end

    assign cpu_gnt   = (state_q == CPU);
    assign ldr_gnt   = (state_q == LDR);
    assign ram_addr  = cpu_gnt ? cpu_addr  : (ldr_gnt ? ldr_addr  : '0);
    assign ram_wdata = cpu_gnt ? cpu_wdata : (ldr_gnt ? ldr_wdata : '0);
    assign ram_we    = (cpu_gnt & cpu_req & cpu_we) | (ldr_gnt & ldr_req & ldr_we);
    assign cpu_stall = cpu_req & ~cpu_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

`ifdef MEM_ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif
    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we, ldr_req, ldr_we;
    logic [3:0] cpu_addr, ldr_addr;
    logic [7:0] cpu_wdata, ldr_wdata;
    logic       cpu_gnt, ldr_gnt, ram_we, cpu_stall;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    // Reference: who owns the port (0 none, 1 cpu, 2 loader), pending turnaround,
    // last owner, and the length of the current run of beats.
    int m_owner;
    bit m_turn;
    int m_last;
    int m_beats;
    bit m_known = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .cpu_gnt   (cpu_gnt),
        .ldr_gnt   (ldr_gnt),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .cpu_stall (cpu_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic       e_cg, e_lg;
        logic [3:0] e_addr;
        logic [7:0] e_data;
        e_cg   = (m_owner == 1);
        e_lg   = (m_owner == 2);
        e_addr = e_cg ? cpu_addr  : (e_lg ? ldr_addr  : 4'h0);
        e_data = e_cg ? cpu_wdata : (e_lg ? ldr_wdata : 8'h00);
        check("cpu_gnt",   32'(cpu_gnt),   32'(e_cg));
        check("ldr_gnt",   32'(ldr_gnt),   32'(e_lg));
        check("ram_addr",  32'(ram_addr),  32'(e_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(e_data));
        check("ram_we",    32'(ram_we),
              32'((e_cg & cpu_req & cpu_we) | (e_lg & ldr_req & ldr_we)));
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cg));
    endtask

    function automatic bit req_of(input int who);
        return (who == 1) ? cpu_req : ldr_req;
    endfunction

    task automatic model_step();
        int w;
        bit own, oth;
        if (reset) begin
            m_owner = 0; m_turn = 1'b0; m_last = 2; m_beats = 0; m_known = 1'b1;
        end else if (m_turn) begin
            w = 3 - m_last;
            if (req_of(w)) begin
                m_owner = w; m_last = w; m_beats = 0;
            end
            m_turn = 1'b0;
        end else if (m_owner == 0) begin
            if (cpu_req && ldr_req) w = (m_last == 2) ? 1 : 2;
            else if (cpu_req)       w = 1;
            else if (ldr_req)       w = 2;
            else                    w = 0;
            if (w != 0) begin
                m_owner = w; m_last = w; m_beats = 0;
            end
        end else begin
            own = req_of(m_owner);
            oth = req_of(3 - m_owner);
            if (!own) begin
                m_owner = 0;
                m_turn  = oth;
            end else begin
                m_beats++;
                if (LIMIT && m_beats >= BURST && oth) begin
                    m_owner = 0;
                    m_turn  = 1'b1;
                end
            end
        end
    endtask

    // Called at posedge+1; drives one cycle of inputs, checks, advances the model.
    task automatic cycle(input bit rst, input bit cr, input bit cw, input logic [3:0] ca,
                         input logic [7:0] cd, input bit lr, input bit lw,
                         input logic [3:0] la, input logic [7:0] ld);
        reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ldr_req = lr; ldr_we = lw; ldr_addr = la; ldr_wdata = ld;
        #1;
        if (m_known) compare_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cnt;
        bit  cr, lr;
        reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        @(posedge clk);
        #1;

        // Reset state with busy-looking data inputs.
        cycle(1, 0, 1, 4'h3, 8'h77, 0, 1, 4'h9, 8'h11);
        check("rst_cpu_gnt",   32'(cpu_gnt),   0);
        check("rst_ldr_gnt",   32'(ldr_gnt),   0);
        check("rst_ram_we",    32'(ram_we),    0);
        check("rst_ram_addr",  32'(ram_addr),  0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);

        // Single CPU request: stall in the request cycle, grant one cycle later.
        cycle(0, 1, 0, 4'h1, 8'h00, 0, 0, 4'h0, 8'h00);
        check("lat_cpu_gnt",   32'(cpu_gnt),   1);
        check("lat_cpu_stall", 32'(cpu_stall), 0);
        cycle(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        cycle(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);

        // Tie after reset: CPU first, then a dead turnaround, then the loader.
        cycle(0, 1, 0, 4'h2, 8'h00, 1, 1, 4'h4, 8'h33);
        check("tie_cpu_gnt", 32'(cpu_gnt), 1);
        check("tie_ldr_gnt", 32'(ldr_gnt), 0);
        cycle(0, 0, 0, 4'h2, 8'h00, 1, 1, 4'h4, 8'h33);
        check("turn_cpu_gnt", 32'(cpu_gnt), 0);
        check("turn_ldr_gnt", 32'(ldr_gnt), 0);
        check("turn_ram_we",  32'(ram_we),  0);
        cycle(0, 0, 0, 4'h0, 8'h00, 1, 1, 4'h4, 8'h33);
        check("turn_then_ldr", 32'(ldr_gnt), 1);

        // Loader write reaches the RAM port in the same cycle.
        cycle(0, 0, 0, 4'h0, 8'h00, 1, 1, 4'hA, 8'h5C);
        check("ldr_wr_we",   32'(ram_we),    1);
        check("ldr_wr_addr", 32'(ram_addr),  32'h0A);
        check("ldr_wr_data", 32'(ram_wdata), 32'h5C);

        // Reset mid-burst kills the grant and the write; next tie goes to CPU.
        cycle(1, 0, 0, 4'h0, 8'h00, 1, 1, 4'hA, 8'h5C);
        check("midrst_ldr_gnt", 32'(ldr_gnt), 0);
        check("midrst_cpu_gnt", 32'(cpu_gnt), 0);
        check("midrst_ram_we",  32'(ram_we),  0);
        cycle(0, 1, 1, 4'h6, 8'hC3, 1, 1, 4'hA, 8'h5C);
        check("midrst_tie_cpu", 32'(cpu_gnt), 1);
        cycle(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        cycle(1, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);

        // Loader holds for 10 cycles against a pending CPU.
        cycle(0, 0, 0, 4'h0, 8'h00, 1, 1, 4'h8, 8'h01);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cnt += int'(ldr_gnt);
            cycle(0, 1, 0, 4'h5, 8'h00, 1, 1, 4'h8, 8'(i));
        end
        check("burst_ldr_cycles", 32'(cnt), LIMIT ? 32'd4 : 32'd10);
        cycle(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
        cycle(0, 0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);

        // Randomized traffic with sticky requests and occasional resets.
        cr = 1'b0;
        lr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) cr = ~cr;
            if ($urandom_range(3, 0) == 0) lr = ~lr;
            cycle($urandom_range(59, 0) == 0, cr, 1'($urandom), 4'($urandom), 8'($urandom),
                  lr, 1'($urandom), 4'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
